// File: rtl/tcdm_bank_responder_pkg.sv
// Shared types and constants for the TCDM bank responder.
// Response stage bundle and wen encoding.
package tcdm_resp_package;
    localparam int TCDM_DW = 32;
    localparam int TCDM_BW = TCDM_DW / 8;
    localparam logic TCDM_WEN_READ = 1'b1;
    localparam logic TCDM_WEN_WRITE = 1'b0;

    typedef struct packed {
        logic               valid;
        logic [TCDM_DW-1:0] data;
    } tcdm_resp_stage_t;
endpackage

// File: rtl/tcdm_bank_responder_if.sv
// TCDM port bundle between a master (streamer) and a bank.
// Request, grant and response signals.
interface tcdm_bank_responder_if;
    import tcdm_resp_package::*;
    logic               req;
    logic               gnt;
    logic [31:0]        add;
    logic               wen;
    logic [TCDM_BW-1:0] be;
    logic [TCDM_DW-1:0] data;
    logic [TCDM_DW-1:0] r_data;
    logic               r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );
    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );
endinterface

// File: rtl/tcdm_bank_responder_pipe.sv
// Fixed-latency response shift register.
// Data only moves with a valid bit, so the head keeps its last word.
module tcdm_resp_pipe
    import tcdm_resp_package::*;
#(
    parameter int LATENCY = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  tcdm_resp_stage_t din,
    output tcdm_resp_stage_t dout
);
    tcdm_resp_stage_t stage [LATENCY];

    // shift stages; clear drops in-flight responses but keeps data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i].valid <= 1'b0;
            end
        end else begin
            stage[0].valid <= din.valid;
            if (din.valid) begin
                stage[0].data <= din.data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage[i].valid <= stage[i-1].valid;
                if (stage[i-1].valid) begin
                    stage[i].data <= stage[i-1].data;
                end
            end
        end
    end

    assign dout = stage[LATENCY-1];
endmodule

// File: rtl/tcdm_bank_responder.sv
// Slave-side TCDM memory bank with fixed response latency,
// grant stalls, access counters and a sticky range error.
module tcdm_bank_responder
    import tcdm_resp_package::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          NB_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 stall_i,
    tcdm_bank_responder_if.slave tcdm,
    output logic [CNT_WIDTH-1:0] rd_cnt_o,
    output logic [CNT_WIDTH-1:0] wr_cnt_o,
    output logic                 err_o
);
    localparam int          AW   = $clog2(NB_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * NB_WORDS);

    logic [DATA_WIDTH-1:0] mem [NB_WORDS];
    logic [31:0]           offset;
    logic                  in_range;
    logic [AW-1:0]         idx;
    logic                  accept;
    logic                  is_read;
    logic                  is_write;
    logic [DATA_WIDTH-1:0] rsp_data;
    tcdm_resp_stage_t      pipe_in;
    tcdm_resp_stage_t      pipe_out;

    assign tcdm.gnt = tcdm.req & ~stall_i & ~clear_i;
    assign accept   = tcdm.req & tcdm.gnt;
    assign is_read  = accept & (tcdm.wen == TCDM_WEN_READ);
    assign is_write = accept & (tcdm.wen == TCDM_WEN_WRITE);

    // subtracting first keeps the range test safe near 2^32
    assign offset   = tcdm.add - BASE_ADDR;
    assign in_range = (tcdm.add >= BASE_ADDR) && (offset < SPAN);
    assign idx      = offset[AW+1:2];

    // byte-lane write at the end of the grant cycle
    always_ff @(posedge clk_i) begin
        if (is_write && in_range) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (tcdm.be[i]) begin
                    mem[idx][8*i +: 8] <= tcdm.data[8*i +: 8];
                end
            end
        end
    end

    // response word: array data, error pattern, or zero for writes
    always_comb begin
        rsp_data = '0;
        if (tcdm.wen == TCDM_WEN_READ) begin
            rsp_data = in_range ? mem[idx] : ERR_DATA;
        end
    end

    assign pipe_in.valid = accept;
    assign pipe_in.data  = rsp_data;

    tcdm_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .din     (pipe_in),
        .dout    (pipe_out)
    );

    assign tcdm.r_valid = pipe_out.valid;
    assign tcdm.r_data  = pipe_out.data;

    // access counters and sticky range error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
            err_o    <= 1'b0;
        end else if (clear_i) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
            err_o    <= 1'b0;
        end else begin
            if (is_read) begin
                rd_cnt_o <= rd_cnt_o + CNT_WIDTH'(1);
            end
            if (is_write) begin
                wr_cnt_o <= wr_cnt_o + CNT_WIDTH'(1);
            end
            if (accept && !in_range) begin
                err_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench: four banks with LATENCY 1..4 share one request stream;
// a scoreboard per bank checks response timing and data.
module tb_tcdm_bank_responder;
    import tcdm_resp_package::*;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        stall = 1'b0;
    logic        req = 1'b0;
    logic        wen = 1'b1;
    logic [31:0] add = '0;
    logic [3:0]  be = '0;
    logic [31:0] data = '0;
    logic [31:0] cur_exp = '0;

    logic [3:0]  gnt_w;
    logic [3:0]  rv_w;
    logic [3:0]  err_w;
    logic [31:0] rd_w [4];
    logic [15:0] rc [4];
    logic [15:0] wc [4];

    exp_t        sb [4][$];
    logic [31:0] last [4];
    vec_t        tbl [$];
    int          cyc = 0;
    int          rd_exp = 0;
    int          wr_exp = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 4; k++) begin : g
        tcdm_bank_responder_if bus ();
        assign bus.req  = req;
        assign bus.add  = add;
        assign bus.wen  = wen;
        assign bus.be   = be;
        assign bus.data = data;
        assign gnt_w[k] = bus.gnt;
        assign rv_w[k]  = bus.r_valid;
        assign rd_w[k]  = bus.r_data;
        tcdm_bank_responder #(
            .LATENCY (k + 1)
        ) dut (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .clear_i  (clear),
            .stall_i  (stall),
            .tcdm     (bus.slave),
            .rd_cnt_o (rc[k]),
            .wr_cnt_o (wc[k]),
            .err_o    (err_w[k])
        );
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         input logic [31:0] e);
        req = 1'b1;
        wen = w;
        add = a;
        be = b;
        data = d;
        cur_exp = e;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        next_cycle();
        req = 1'b0;
        repeat (6) next_cycle();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rvalid"}, {28'b0, rv_w}, 32'h0);
        check({tag, "_err"}, {28'b0, err_w}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_rdata_l%0d", tag, k + 1), rd_w[k], 32'h0);
            check($sformatf("%s_rdcnt_l%0d", tag, k + 1), {16'b0, rc[k]}, 32'h0);
            check($sformatf("%s_wrcnt_l%0d", tag, k + 1), {16'b0, wc[k]}, 32'h0);
        end
    endtask

    task automatic check_counts(input string tag);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_rdcnt_l%0d", tag, k + 1), {16'b0, rc[k]},
                  32'(rd_exp[15:0]));
            check($sformatf("%s_wrcnt_l%0d", tag, k + 1), {16'b0, wc[k]},
                  32'(wr_exp[15:0]));
        end
    endtask

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                sb[k].delete();
                last[k] = '0;
            end
            rd_exp = 0;
            wr_exp = 0;
        end else begin
            check("gnt", {28'b0, gnt_w}, {28'b0, {4{req & ~stall & ~clear}}});
            for (int k = 0; k < 4; k++) begin
                if (rv_w[k]) begin
                    if (sb[k].size() == 0) begin
                        check($sformatf("spurious_rvalid_l%0d", k + 1), 1, 0);
                    end else begin
                        exp_t e;
                        e = sb[k].pop_front();
                        check($sformatf("rsp_cycle_l%0d", k + 1), cyc, e.due);
                        check($sformatf("rsp_data_l%0d", k + 1), rd_w[k], e.data);
                    end
                    last[k] = rd_w[k];
                end else begin
                    check($sformatf("rdata_hold_l%0d", k + 1), rd_w[k], last[k]);
                    if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
                        check($sformatf("missing_rvalid_l%0d", k + 1), 0, 1);
                        void'(sb[k].pop_front());
                    end
                end
            end
            if (req && !stall && !clear) begin
                for (int k = 0; k < 4; k++) begin
                    sb[k].push_back(exp_t'{cyc + k + 1, cur_exp});
                end
                if (wen == TCDM_WEN_READ) rd_exp++;
                else wr_exp++;
            end
            if (clear) begin
                for (int k = 0; k < 4; k++) sb[k].delete();
                rd_exp = 0;
                wr_exp = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back(vec_t'{TCDM_WEN_WRITE, 32'h1000_0010, 4'hF, 32'hA5A5_1234, 32'h0});
        tbl.push_back(vec_t'{TCDM_WEN_READ,  32'h1000_0010, 4'h0, 32'h0, 32'hA5A5_1234});
        tbl.push_back(vec_t'{TCDM_WEN_WRITE, 32'h1000_0020, 4'hF, 32'h1111_1111, 32'h0});
        tbl.push_back(vec_t'{TCDM_WEN_WRITE, 32'h1000_0020, 4'h5, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back(vec_t'{TCDM_WEN_READ,  32'h1000_0020, 4'h0, 32'h0, 32'h11FF_11FF});
        tbl.push_back(vec_t'{TCDM_WEN_WRITE, 32'h1000_0010, 4'h0, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back(vec_t'{TCDM_WEN_READ,  32'h1000_0013, 4'h0, 32'h0, 32'hA5A5_1234});
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(vec_t'{TCDM_WEN_WRITE, 32'h1000_0100 + 32'(4 * i), 4'hF,
                                 32'hC0DE_0000 + 32'(i), 32'h0});
        end
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(vec_t'{TCDM_WEN_READ, 32'h1000_0100 + 32'(4 * i), 4'h0,
                                 32'h0, 32'hC0DE_0000 + 32'(i)});
        end
        tbl.push_back(vec_t'{TCDM_WEN_WRITE, 32'h1000_0000, 4'hF, 32'h0BAD_F00D, 32'h0});
        tbl.push_back(vec_t'{TCDM_WEN_READ,  32'h0FFF_FFFC, 4'h0, 32'h0, 32'hDEAD_BEEF});
        tbl.push_back(vec_t'{TCDM_WEN_WRITE, 32'h1000_1000, 4'hF, 32'h1234_5678, 32'h0});
        tbl.push_back(vec_t'{TCDM_WEN_READ,  32'h1000_0000, 4'h0, 32'h0, 32'h0BAD_F00D});

        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            next_cycle();
            if (tbl[i].a == 32'h0FFF_FFFC) begin
                check("err_before_oor", {28'b0, err_w}, 32'h0);
            end
            drive(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].e);
        end
        drain();
        check("err_after_oor", {28'b0, err_w}, 32'hF);
        check_counts("table");

        stall = 1'b1;
        drive(TCDM_WEN_READ, 32'h1000_0010, 4'h0, 32'h0, 32'hA5A5_1234);
        repeat (4) next_cycle();
        stall = 1'b0;
        drain();
        check_counts("stall");

        drive(TCDM_WEN_READ, 32'h1000_0104, 4'h0, 32'h0, 32'hC0DE_0001);
        next_cycle();
        req = 1'b0;
        next_cycle();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
        repeat (6) next_cycle();
        check("err_after_clear", {28'b0, err_w}, 32'h0);
        check_counts("clear");

        drive(TCDM_WEN_WRITE, 32'h1000_0040, 4'hF, 32'h5A5A_0F0F, 32'h0);
        next_cycle();
        drive(TCDM_WEN_READ, 32'h1000_0040, 4'h0, 32'h0, 32'h5A5A_0F0F);
        next_cycle();
        req = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_zero("midreset");
        #1 rst_n = 1'b1;
        repeat (6) next_cycle();
        drive(TCDM_WEN_READ, 32'h1000_0040, 4'h0, 32'h0, 32'h5A5A_0F0F);
        next_cycle();
        drive(TCDM_WEN_READ, 32'h1000_0020, 4'h0, 32'h0, 32'h11FF_11FF);
        drain();
        check_counts("after_reset");
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sb_empty_l%0d", k + 1), sb[k].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
